counter_nbit: RTL and testbench
===============================

COUNTER_NBIT -- requirements
Module: counter_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning count register width in bits (legal range 2..32).
REQ-002 SHALL have parameter MOD, default 2**WIDTH, meaning count modulus; the legal count range is 0..MOD-1, with 2 <= MOD <= 2**WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-008 SHALL have port load_data, input, WIDTH bits: value to load.
REQ-009 SHALL have port count, output, WIDTH bits: registered count value.
REQ-010 SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-011 SHALL have port sat, input, 1 bit, only when COUNTER_NBIT_SAT_EN is defined: selects saturate mode (1) or wrap mode (0).

Function
REQ-012 SHALL apply priority reset > load > en on each rising clk edge.
REQ-013 SHALL, on load=1, set count to load_data on the next edge, or to MOD-1 when load_data >= MOD; load SHALL take effect regardless of en.
REQ-014 SHALL, on en=1 with up=1 in wrap mode, advance count to count+1, or to 0 when count=MOD-1.
REQ-015 SHALL, on en=1 with up=0 in wrap mode, retreat count to count-1, or to MOD-1 when count=0.
REQ-016 SHALL hold count when en=0 and load=0.
REQ-017 SHALL assert tc for exactly one cycle, registered with count, in the cycle after a wrap transition (MOD-1->0 or 0->MOD-1); tc SHALL be 0 otherwise.
REQ-018 SHALL never assert tc on load, even when the loaded value equals the boundary value.
REQ-019 SHALL produce count and tc with one-cycle latency from the inputs sampled at the edge; there is no combinational path from inputs to outputs.
REQ-020 SHALL compute the next count at WIDTH+1 bits internally so that MOD=2**WIDTH wraps without overflow ambiguity.
REQ-021 SHALL keep tc asserted for consecutive cycles when back-to-back wraps occur (MOD=2, en held high).

Reset
REQ-022 SHALL, with reset=1 at a rising edge, set count=0 and tc=0, overriding load and en.
REQ-023 SHALL, when reset is asserted during a counting run, force count=0 on that edge; the first increment SHALL occur on the first edge with reset=0 and en=1.
REQ-024 SHALL leave outputs undefined before the first reset edge.

Configuration
REQ-025 SHALL, with macro COUNTER_NBIT_SAT_EN defined, provide the sat port; with sat=1, count SHALL hold at MOD-1 when counting up and at 0 when counting down, and tc SHALL stay 0.
REQ-026 SHALL, without COUNTER_NBIT_SAT_EN, omit the sat port and always wrap as in REQ-014 and REQ-015.

Structure
REQ-027 SHALL place the direction enum (DIR_DOWN=0, DIR_UP=1) and the WIDTH/MOD legality-check function in shared package counter_pkg.
REQ-028 SHALL implement the next-value and wrap-detect logic in the combinational sub-module counter_nbit_next, instantiated once; count and tc registers SHALL reside in counter_nbit.
REQ-029 SHALL flag illegal WIDTH/MOD combinations with an elaboration-time error.

Verification
REQ-030 SHALL cover reset then count up: WIDTH=4, MOD=10, reset 1 cycle, then en=1 and up=1 for 12 cycles -> count 0,1,...,9,0,1,2; tc=1 only in the cycle count shows 0 after 9.
REQ-031 SHALL cover load then count down: load=1 with load_data=7, then en=1 and up=0 -> count 7,6,...,0,9; tc=1 in the cycle count shows 9.
REQ-032 SHALL cover out-of-range load: MOD=10, load_data=4'hC -> count=9 and tc=0.
REQ-033 SHALL cover simultaneous events: reset=1, load=1 and en=1 together -> count=0; then load=1 and en=1 with load_data=5 -> count=5, not 6.
REQ-034 SHALL cover saturate mode with COUNTER_NBIT_SAT_EN defined: sat=1, up=1, start at 8 -> count 9,9,9 with tc=0; then up=0 from 1 -> count 0,0 with tc=0.
REQ-035 SHALL cover full-range wrap: WIDTH=4, MOD=16, count at 15, en=1 and up=1 -> count=0 and tc=1; then hold with en=0 -> count=0 and tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter_nbit slice.
//   dir_e             : count direction encoding (DIR_DOWN=0, DIR_UP=1)
//   counter_params_ok : WIDTH/MOD legality check used at elaboration time
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Legal when 2 <= width <= 32 and 2 <= mod <= 2**width.
  function automatic bit counter_params_ok(input int unsigned width,
                                           input longint unsigned mod);
    if (width < 2 || width > 32) return 1'b0;
    if (mod < 2) return 1'b0;
    if (mod > (64'd1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/counter_nbit_next.sv
// Combinational next-value and wrap detection for counter_nbit.
// Ports:
//   count      in  WIDTH  current registered count
//   up         in  1      direction (1 up, 0 down)
//   sat        in  1      1 = saturate at the boundary, 0 = wrap
//   next_count out WIDTH  value the count takes when enabled
//   wrap       out 1      next_count is a wrap transition (MOD-1->0 or 0->MOD-1)
module counter_nbit_next
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  // Arithmetic is done one bit wider so MOD = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  dir_e           dir;
  logic [WIDTH:0] wide;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  assign dir  = dir_e'(up);
  assign wide = {1'b0, count};
  assign inc  = wide + 1'b1;
  assign dec  = wide - 1'b1;

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    if (dir == DIR_UP) begin
      if (inc == MOD_W) begin
        if (!sat) begin
          next_count = '0;
          wrap       = 1'b1;
        end
      end else begin
        next_count = WIDTH'(inc);
      end
    end else begin
      if (count == '0) begin
        if (!sat) begin
          next_count = MAX_V;
          wrap       = 1'b1;
        end
      end else begin
        next_count = WIDTH'(dec);
      end
    end
  end

endmodule

// File: rtl/counter_nbit.sv
// Modulo-MOD up/down counter with parallel load and registered terminal-count.
// Optional feature macro: COUNTER_NBIT_SAT_EN adds the sat input (saturate mode).
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset (count=0, tc=0)
//   en         in  1      count enable
//   up         in  1      direction (1 up, 0 down)
//   load       in  1      parallel load strobe (beats en)
//   load_data  in  WIDTH  load value, clamped to MOD-1
//   sat        in  1      (COUNTER_NBIT_SAT_EN only) 1 saturate, 0 wrap
//   count      out WIDTH  registered count
//   tc         out 1      registered one-cycle pulse after a wrap transition
module counter_nbit
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef COUNTER_NBIT_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (!counter_params_ok(WIDTH, MOD)) begin : g_illegal_params
    $error("counter_nbit: illegal WIDTH=%0d MOD=%0d", WIDTH, MOD);
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic             sat_mode;
  logic [WIDTH-1:0] next_count;
  logic             wrap;
  logic [WIDTH-1:0] load_value;

`ifdef COUNTER_NBIT_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  assign load_value = ({1'b0, load_data} >= MOD_W) ? MAX_V : load_data;

  counter_nbit_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .count      (count),
    .up         (up),
    .sat        (sat_mode),
    .next_count (next_count),
    .wrap       (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_value;
      tc    <= 1'b0;
    end else if (en) begin
      count <= next_count;
      tc    <= wrap;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_nbit.sv
module tb_counter_nbit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_data = '0;
  logic       sat = 1'b0;

  logic [3:0] count10, count16;
  logic [1:0] count2;
  logic       tc10, tc16, tc2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_nbit #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_data(load_data),
`ifdef COUNTER_NBIT_SAT_EN
    .sat(sat),
`endif
    .count(count10), .tc(tc10)
  );

  counter_nbit #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_data(load_data),
`ifdef COUNTER_NBIT_SAT_EN
    .sat(1'b0),
`endif
    .count(count16), .tc(tc16)
  );

  counter_nbit #(.WIDTH(2), .MOD(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_data(load_data[1:0]),
`ifdef COUNTER_NBIT_SAT_EN
    .sat(1'b0),
`endif
    .count(count2), .tc(tc2)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       ld;
    logic       en;
    logic       up;
    logic [3:0] data;
    logic [3:0] exp_count;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic ld,
                     input logic e, input logic u, input logic [3:0] data,
                     input logic [3:0] ec, input logic et);
    vec_t v;
    v.name = name; v.rst = rst; v.ld = ld; v.en = e; v.up = u;
    v.data = data; v.exp_count = ec; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic e,
                      input logic u, input logic [3:0] data);
    reset = rst; load = ld; en = e; up = u; load_data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Modulus-10 vectors: {name, reset, load, en, up, load_data, count, tc}
    add("reset",        1, 0, 0, 1, 4'h0, 0, 0);
    add("up1",          0, 0, 1, 1, 4'h0, 1, 0);
    add("up2",          0, 0, 1, 1, 4'h0, 2, 0);
    add("up3",          0, 0, 1, 1, 4'h0, 3, 0);
    add("up4",          0, 0, 1, 1, 4'h0, 4, 0);
    add("up5",          0, 0, 1, 1, 4'h0, 5, 0);
    add("up6",          0, 0, 1, 1, 4'h0, 6, 0);
    add("up7",          0, 0, 1, 1, 4'h0, 7, 0);
    add("up8",          0, 0, 1, 1, 4'h0, 8, 0);
    add("up9",          0, 0, 1, 1, 4'h0, 9, 0);
    add("up_wrap0",     0, 0, 1, 1, 4'h0, 0, 1);
    add("up_after1",    0, 0, 1, 1, 4'h0, 1, 0);
    add("up_after2",    0, 0, 1, 1, 4'h0, 2, 0);
    add("load7",        0, 1, 0, 1, 4'h7, 7, 0);
    add("dn6",          0, 0, 1, 0, 4'h0, 6, 0);
    add("dn5",          0, 0, 1, 0, 4'h0, 5, 0);
    add("dn4",          0, 0, 1, 0, 4'h0, 4, 0);
    add("dn3",          0, 0, 1, 0, 4'h0, 3, 0);
    add("dn2",          0, 0, 1, 0, 4'h0, 2, 0);
    add("dn1",          0, 0, 1, 0, 4'h0, 1, 0);
    add("dn0",          0, 0, 1, 0, 4'h0, 0, 0);
    add("dn_wrap9",     0, 0, 1, 0, 4'h0, 9, 1);
    add("dn8",          0, 0, 1, 0, 4'h0, 8, 0);
    add("load_oor_C",   0, 1, 1, 1, 4'hC, 9, 0);
    add("load9_no_tc",  0, 1, 0, 1, 4'h9, 9, 0);
    add("load0_no_tc",  0, 1, 1, 0, 4'h0, 0, 0);
    add("rst_ld_en",    1, 1, 1, 1, 4'h3, 0, 0);
    add("ld_en_5",      0, 1, 1, 1, 4'h5, 5, 0);
    add("hold5",        0, 0, 0, 1, 4'h0, 5, 0);
    add("up_from5",     0, 0, 1, 1, 4'h0, 6, 0);
    add("rst_midrun",   1, 0, 1, 1, 4'h0, 0, 0);
    add("first_inc",    0, 0, 1, 1, 4'h0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].data);
      check({vecs[i].name, ".count"}, int'(count10), int'(vecs[i].exp_count));
      check({vecs[i].name, ".tc"},    int'(tc10),    int'(vecs[i].exp_tc));
    end

    // Full-range wrap on MOD=16
    step(0, 1, 0, 1, 4'hF);
    check("m16_load15", int'(count16), 15);
    step(0, 0, 1, 1, 4'h0);
    check("m16_wrap_count", int'(count16), 0);
    check("m16_wrap_tc", int'(tc16), 1);
    step(0, 0, 0, 1, 4'h0);
    check("m16_hold_count", int'(count16), 0);
    check("m16_hold_tc", int'(tc16), 0);
    step(0, 0, 1, 0, 4'h0);
    check("m16_dnwrap_count", int'(count16), 15);
    check("m16_dnwrap_tc", int'(tc16), 1);

    // Modulus-2: alternating direction gives a wrap on every edge
    step(1, 0, 0, 1, 4'h0);
    check("m2_reset", int'(count2), 0);
    step(0, 0, 1, 0, 4'h0);
    check("m2_b2b1_count", int'(count2), 1);
    check("m2_b2b1_tc", int'(tc2), 1);
    step(0, 0, 1, 1, 4'h0);
    check("m2_b2b2_count", int'(count2), 0);
    check("m2_b2b2_tc", int'(tc2), 1);
    step(0, 0, 1, 0, 4'h0);
    check("m2_b2b3_count", int'(count2), 1);
    check("m2_b2b3_tc", int'(tc2), 1);
    step(0, 0, 0, 0, 4'h0);
    check("m2_idle_tc", int'(tc2), 0);

`ifdef COUNTER_NBIT_SAT_EN
    sat = 1'b1;
    step(0, 1, 0, 1, 4'h8);
    check("sat_load8", int'(count10), 8);
    for (int unsigned k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 4'h0);
      check("sat_up_count", int'(count10), 9);
      check("sat_up_tc", int'(tc10), 0);
    end
    step(0, 1, 0, 0, 4'h1);
    check("sat_load1", int'(count10), 1);
    for (int unsigned k = 0; k < 2; k++) begin
      step(0, 0, 1, 0, 4'h0);
      check("sat_dn_count", int'(count10), 0);
      check("sat_dn_tc", int'(tc10), 0);
    end
    sat = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
